// File: rtl/cache_arb_pkg.sv
// Shared definitions for the cache-side memory port arbiter: request type codes,
// read-sequencer states and line geometry defaults.
package cache_arb_pkg;

  localparam int LINE_BYTES = 16;
  localparam int OFF_W      = $clog2(LINE_BYTES);

  localparam logic [2:0] TYPE_BYTE = 3'b000;
  localparam logic [2:0] TYPE_HALF = 3'b001;
  localparam logic [2:0] TYPE_WORD = 3'b010;
  localparam logic [2:0] TYPE_LINE = 3'b100;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_RESP = 2'd2
  } rd_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. Bit 0 is the I-cache, bit 1 the D-cache;
// after reset the D-cache wins a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_gnt
);

  // r_last is the index of the requester granted most recently
  logic r_last;

  always_comb begin
    o_gnt = i_req;
    if (i_req[0] && i_req[1]) begin
      o_gnt = r_last ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= 1'b0;
    end else if (i_accept && (|o_gnt)) begin
      r_last <= o_gnt[1];
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the bridge memory port between I-cache and D-cache: round-robin read
// arbitration with return routing, plus a one-line D-cache write buffer.
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int LINE_BYTES = 16,
  parameter int ADDR_W     = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ic_rd_req,
  input  logic [2:0]              ic_rd_type,
  input  logic [ADDR_W-1:0]       ic_rd_addr,
  output logic                    ic_rd_rdy,
  output logic                    ic_ret_valid,
  output logic                    ic_ret_last,
  output logic [31:0]             ic_ret_data,
  input  logic                    dc_rd_req,
  input  logic [2:0]              dc_rd_type,
  input  logic [ADDR_W-1:0]       dc_rd_addr,
  output logic                    dc_rd_rdy,
  output logic                    dc_ret_valid,
  output logic                    dc_ret_last,
  output logic [31:0]             dc_ret_data,
  input  logic                    dc_wr_req,
  input  logic [2:0]              dc_wr_type,
  input  logic [ADDR_W-1:0]       dc_wr_addr,
  input  logic [3:0]              dc_wr_wstrb,
  input  logic [LINE_BYTES*8-1:0] dc_wr_data,
  output logic                    dc_wr_rdy,
  output logic                    mem_rd_req,
  output logic [2:0]              mem_rd_type,
  output logic [ADDR_W-1:0]       mem_rd_addr,
  input  logic                    mem_rd_rdy,
  input  logic                    mem_ret_valid,
  input  logic                    mem_ret_last,
  input  logic [31:0]             mem_ret_data,
  output logic                    mem_wr_req,
  output logic [2:0]              mem_wr_type,
  output logic [ADDR_W-1:0]       mem_wr_addr,
  output logic [3:0]              mem_wr_wstrb,
  output logic [LINE_BYTES*8-1:0] mem_wr_data,
  input  logic                    mem_wr_rdy
);

  localparam int OFF_BITS = $clog2(LINE_BYTES);

  rd_state_t               r_state;
  rd_state_t               w_state_next;
  logic                    r_owner;
  logic [2:0]              r_type;
  logic [ADDR_W-1:0]       r_addr;

  logic                    r_wb_valid;
  logic [2:0]              r_wb_type;
  logic [ADDR_W-1:0]       r_wb_addr;
  logic [3:0]              r_wb_wstrb;
  logic [LINE_BYTES*8-1:0] r_wb_data;

  logic                    w_ic_haz;
  logic                    w_dc_haz;
  logic                    w_idle;
  logic [1:0]              w_elig;
  logic [1:0]              w_gnt;

  // A read to the line sitting in the write buffer must wait until it drains
  assign w_ic_haz = r_wb_valid && (ic_rd_addr[ADDR_W-1:OFF_BITS] == r_wb_addr[ADDR_W-1:OFF_BITS]);
  assign w_dc_haz = r_wb_valid && (dc_rd_addr[ADDR_W-1:OFF_BITS] == r_wb_addr[ADDR_W-1:OFF_BITS]);
  assign w_idle   = (r_state == R_IDLE) && !reset;
  assign w_elig   = w_idle ? {dc_rd_req && !w_dc_haz, ic_rd_req && !w_ic_haz} : 2'b00;

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .reset    (reset),
    .i_req    (w_elig),
    .i_accept (w_idle),
    .o_gnt    (w_gnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= R_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      R_IDLE:  if (|w_gnt) w_state_next = R_REQ;
      R_REQ:   if (mem_rd_rdy) w_state_next = R_RESP;
      R_RESP:  if (mem_ret_valid && mem_ret_last) w_state_next = R_IDLE;
      default: w_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    ic_rd_rdy    = w_gnt[0];
    dc_rd_rdy    = w_gnt[1];
    mem_rd_req   = (r_state == R_REQ);
    ic_ret_valid = 1'b0;
    ic_ret_last  = 1'b0;
    ic_ret_data  = '0;
    dc_ret_valid = 1'b0;
    dc_ret_last  = 1'b0;
    dc_ret_data  = '0;
    if (r_state == R_RESP) begin
      if (r_owner) begin
        dc_ret_valid = mem_ret_valid;
        dc_ret_last  = mem_ret_last;
        dc_ret_data  = mem_ret_data;
      end else begin
        ic_ret_valid = mem_ret_valid;
        ic_ret_last  = mem_ret_last;
        ic_ret_data  = mem_ret_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner <= 1'b0;
      r_type  <= '0;
      r_addr  <= '0;
    end else if (|w_gnt) begin
      r_owner <= w_gnt[1];
      r_type  <= w_gnt[1] ? dc_rd_type : ic_rd_type;
      r_addr  <= w_gnt[1] ? dc_rd_addr : ic_rd_addr;
    end
  end

  assign mem_rd_type = r_type;
  assign mem_rd_addr = r_addr;

  // Accept only when empty, so accept and drain never coincide
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wb_valid <= 1'b0;
      r_wb_type  <= '0;
      r_wb_addr  <= '0;
      r_wb_wstrb <= '0;
      r_wb_data  <= '0;
    end else if (r_wb_valid) begin
      if (mem_wr_rdy) begin
        r_wb_valid <= 1'b0;
      end
    end else if (dc_wr_req) begin
      r_wb_valid <= 1'b1;
      r_wb_type  <= dc_wr_type;
      r_wb_addr  <= dc_wr_addr;
      r_wb_wstrb <= dc_wr_wstrb;
      r_wb_data  <= dc_wr_data;
    end
  end

  assign dc_wr_rdy    = !r_wb_valid && !reset;
  assign mem_wr_req   = r_wb_valid;
  assign mem_wr_type  = r_wb_type;
  assign mem_wr_addr  = r_wb_addr;
  assign mem_wr_wstrb = r_wb_wstrb;
  assign mem_wr_data  = r_wb_data;

endmodule
